sol_stream_sequencer: RTL and testbench
=======================================

// Module: sol_stream_sequencer
// PURPOSE
// - Runs one puzzle pass on a byte-serial solver. Clears the solver, streams LEN bytes from a
//   byte RAM into the solver's char_in/input_valid/input_ready port, then captures its 64-bit result.
// - Sits between the testbench/host loader RAM and any solution core; one sequencer per core.
// PARAMETERS
// - ADDR_W      16    RAM byte-address width; max LEN = 2**ADDR_W-1
// - CLR_CYCLES  4     cycles sol_rst_n is held low before streaming (>=1)
// - SETTLE      2     idle cycles after last accepted byte before result may be sampled (>=1)
// - TIMEOUT     1024  max cycles in WAIT_RES before err_timeout
// - APPEND_NL   1     1: send extra 0x0A if last RAM byte != 0x0A (solver commits a line on LF)
// PORTS
// - clk           in   1       clock, all logic on posedge
// - rst           in   1       synchronous, active-high reset
// - start         in   1       pulse: begin a pass (sampled only in IDLE)
// - len           in   ADDR_W  byte count, sampled with start
// - mem_addr      out  ADDR_W  RAM read address
// - mem_rd        out  1       RAM read strobe; mem_rdata valid exactly 1 cycle later
// - mem_rdata     in   8       RAM read data
// - sol_rst_n     out  1       solver reset, active-low (registered)
// - sol_valid     out  1       -> solver input_valid
// - sol_char      out  8       -> solver char_in
// - sol_ready     in   1       <- solver input_ready
// - sol_result    in   64      <- solver result
// - sol_out_valid in   1       <- solver output_valid
// - busy          out  1       high from accepted start until DONE
// - done          out  1       one-cycle pulse when result/err_timeout are final
// - result        out  64      captured solver result; holds until next start
// - bytes_sent    out  ADDR_W+1 bytes accepted by solver this pass (incl. appended LF)
// - err_timeout   out  1       sticky for the pass; cleared on next start
// BEHAVIOUR
// - Reset: state IDLE; sol_rst_n=0, sol_valid=0, mem_rd=0, busy=0, done=0, result=0,
//   bytes_sent=0, err_timeout=0, mem_addr=0. Reset mid-pass aborts immediately; no done pulse.
// - FSM: IDLE -> CLEAR -> STREAM -> [APPEND] -> SETTLE -> WAIT_RES -> DONE -> IDLE.
// - IDLE: sol_rst_n=0. start=1 -> latch len, clear result/bytes_sent/err_timeout, busy=1, CLEAR.
// - CLEAR: sol_rst_n=0 for CLR_CYCLES cycles, then sol_rst_n=1 and STREAM. len=0 -> skip to
//   APPEND if APPEND_NL else SETTLE.
// - STREAM: prefetch via 2-entry skid buffer; mem_rd issued when (entries + reads in flight) < 2
//   and issued_count < len; mem_addr increments per read, starts at 0. sol_valid = buffer
//   non-empty; sol_char = head entry. Handshake = sol_valid & sol_ready; pops head,
//   bytes_sent++. Sustains 1 byte/cycle with sol_ready=1 after 2-cycle fill. sol_valid/sol_char
//   must stay stable while sol_ready=0. Leave when len bytes accepted: last byte==0x0A or
//   APPEND_NL=0 -> SETTLE, else APPEND.
// - APPEND: sol_valid=1, sol_char=0x0A until handshake, bytes_sent++, -> SETTLE.
// - SETTLE: sol_valid=0 for SETTLE cycles, -> WAIT_RES. sol_out_valid ignored in all states
//   before WAIT_RES (solver raises it on any valid bubble).
// - WAIT_RES: first cycle sol_out_valid=1 -> result<=sol_result, DONE. TIMEOUT cycles without
//   it -> err_timeout=1, result unchanged (0), DONE.
// - DONE: done=1 one cycle, busy=0 next cycle, -> IDLE. sol_rst_n stays 1 in DONE; IDLE
//   re-asserts it low.
// - start while busy: ignored, no effect. start in the DONE cycle ignored.
// - Counters: bytes_sent is ADDR_W+1 bits so len=max plus LF does not wrap; mem_addr never
//   exceeds len-1.
// STRUCTURE
// - sol_seq_pkg: state enum (IDLE,CLEAR,STREAM,APPEND,SETTLE,WAIT_RES,DONE), ASCII_LF=8'h0A.
// - Sub-module sol_seq_skid: 2-entry byte FIFO, push/pop/count, same clk/rst; this block owns
//   the in-flight read tracking.
// TESTING
// - len=3 "ab\n", sol_ready=1 -> 3 handshakes on consecutive cycles, no append, bytes_sent=3,
//   done pulses once.
// - len=2 "ab", APPEND_NL=1 -> 3 handshakes, third sol_char=0x0A, bytes_sent=3.
// - sol_ready toggled 1,0,0,1,... during STREAM -> sol_char stable while stalled, order and
//   count exact, no extra mem_rd.
// - Day-2 style line "Game 7: 3 red\n" into real solver core -> result=7 captured in WAIT_RES.
// - len=0, APPEND_NL=1 -> single LF sent, bytes_sent=1; sol_out_valid held 0 -> err_timeout=1
//   after 1024 cycles, result=0.
// - rst pulsed mid-STREAM, then start len=1 -> busy=0/sol_rst_n=0 after reset; new pass from
//   mem_addr=0, full CLR_CYCLES clear.

Source files
------------

// File: rtl/sol_seq_pkg.sv
// Shared types for the solver stream sequencer: FSM states, skid depth, line terminator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sol_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_APPEND,
    ST_SETTLE,
    ST_WAIT_RES,
    ST_DONE
  } state_t;

  // Prefetch buffer depth; two entries cover the one-cycle RAM read latency at full rate.
  localparam int SKID_DEPTH = 2;

  // The solver commits a line when it sees LF.
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sol_seq_skid.sv
// Two-entry byte FIFO fed by a one-cycle-latency RAM; tracks the read in flight.
// Latency: byte visible at head 2 cycles after rd_issue (issue, RAM return, push).
// Backpressure: can_issue low when entries + in-flight reads would overflow; a same-cycle pop frees a slot.
module sol_seq_skid
  import sol_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       rd_issue,
  input  logic [7:0] rd_dat,
  input  logic       pop,
  output logic       head_vld,
  output logic [7:0] head_dat,
  output logic       can_issue
);

  logic [7:0] mem [SKID_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       inflight;
  logic [1:0] count;
  logic       push;

  // RAM data returns exactly one cycle after the read, so the in-flight flag is the push strobe.
  assign push      = inflight;
  assign head_vld  = (count != 2'd0);
  assign head_dat  = mem[rd_ptr];
  // Counting a same-cycle pop as a free slot is what allows one byte per cycle.
  assign can_issue = ((count + {1'b0, inflight}) < 2'(SKID_DEPTH)) || pop;

  // Pointer, occupancy and in-flight tracking; clr flushes between passes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= rd_dat;
  end

endmodule

// File: rtl/sol_stream_sequencer.sv
// Runs one solver pass: clear the core, stream LEN RAM bytes (plus optional LF), capture the 64-bit result.
// Latency: CLR_CYCLES + 2-cycle fill + LEN (+1) bytes + SETTLE + result wait (<= TIMEOUT) + 1 DONE cycle.
// Backpressure: sol_valid/sol_char hold while sol_ready is low; RAM reads stop once the skid buffer is full.
module sol_stream_sequencer
  import sol_seq_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int CLR_CYCLES = 4,
  parameter int SETTLE     = 2,
  parameter int TIMEOUT    = 1024,
  parameter bit APPEND_NL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              sol_rst_n,
  output logic              sol_valid,
  output logic [7:0]        sol_char,
  input  logic              sol_ready,
  input  logic [63:0]       sol_result,
  input  logic              sol_out_valid,
  output logic              busy,
  output logic              done,
  output logic [63:0]       result,
  output logic [ADDR_W:0]   bytes_sent,
  output logic              err_timeout
);

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W:0]   len_ext;
  logic [ADDR_W:0]   issued_cnt;
  logic [31:0]       cnt;
  logic              head_vld;
  logic [7:0]        head_dat;
  logic              can_issue;
  logic              hs;
  logic              pop;
  logic              skid_clr;

  assign len_ext   = {1'b0, len_q};
  assign sol_valid = ((state == ST_STREAM) && head_vld) || (state == ST_APPEND);
  assign sol_char  = (state == ST_APPEND) ? ASCII_LF : head_dat;
  assign hs        = sol_valid && sol_ready;
  assign pop       = hs && (state == ST_STREAM);
  assign mem_rd    = (state == ST_STREAM) && (issued_cnt < len_ext) && can_issue;
  // Nothing is in flight when STREAM exits, so flushing outside STREAM loses no data.
  assign skid_clr  = (state != ST_STREAM);

  sol_seq_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (skid_clr),
    .rd_issue  (mem_rd),
    .rd_dat    (mem_rdata),
    .pop       (pop),
    .head_vld  (head_vld),
    .head_dat  (head_dat),
    .can_issue (can_issue)
  );

  // Pass sequencing, read addressing, byte accounting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= '0;
      issued_cnt  <= '0;
      mem_addr    <= '0;
      cnt         <= 32'd0;
      sol_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 64'd0;
      bytes_sent  <= '0;
      err_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      // Address stops at len-1 so it never points past the data.
      if (mem_rd) begin
        issued_cnt <= issued_cnt + 1'b1;
        if ((issued_cnt + 1'b1) < len_ext) mem_addr <= mem_addr + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          sol_rst_n <= 1'b0;
          if (start) begin
            len_q       <= len;
            result      <= 64'd0;
            bytes_sent  <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b1;
            issued_cnt  <= '0;
            mem_addr    <= '0;
            cnt         <= 32'd0;
            state       <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (cnt == 32'(CLR_CYCLES - 1)) begin
            cnt       <= 32'd0;
            sol_rst_n <= 1'b1;
            if (len_q == '0) state <= APPEND_NL ? ST_APPEND : ST_SETTLE;
            else             state <= ST_STREAM;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_STREAM: begin
          if (hs) begin
            bytes_sent <= bytes_sent + 1'b1;
            if ((bytes_sent + 1'b1) == len_ext) begin
              cnt <= 32'd0;
              if (!APPEND_NL || (head_dat == ASCII_LF)) state <= ST_SETTLE;
              else                                       state <= ST_APPEND;
            end
          end
        end
        ST_APPEND: begin
          if (hs) begin
            bytes_sent <= bytes_sent + 1'b1;
            cnt        <= 32'd0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == 32'(SETTLE - 1)) begin
            cnt   <= 32'd0;
            state <= ST_WAIT_RES;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_WAIT_RES: begin
          if (sol_out_valid) begin
            result <= sol_result;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (cnt == 32'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_DONE: begin
          busy      <= 1'b0;
          sol_rst_n <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sol_stream_sequencer.sv
// Bench for sol_stream_sequencer: RAM model, small line-parsing solver, byte scoreboard.
// Latency: n/a.
// Backpressure: sol_ready driven always-high or in a 1,0,0 pattern.
module tb_sol_stream_sequencer;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] len;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_rdata;
  logic          sol_rst_n;
  logic          sol_valid;
  logic [7:0]    sol_char;
  logic          sol_ready;
  logic [63:0]   sol_result;
  logic          sol_out_valid;
  logic          busy;
  logic          done;
  logic [63:0]   result;
  logic [AW:0]   bytes_sent;
  logic          err_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int addr_bad = 0;

  logic [7:0]  ram [0:255];
  logic [7:0]  exp_q [$];
  logic        ov_block;
  logic [63:0] sum_m;
  int          id_m;
  logic        colon_m;

  always #5 clk = ~clk;

  sol_stream_sequencer #(
    .ADDR_W(AW), .CLR_CYCLES(4), .SETTLE(2), .TIMEOUT(1024), .APPEND_NL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .sol_rst_n(sol_rst_n), .sol_valid(sol_valid), .sol_char(sol_char), .sol_ready(sol_ready),
    .sol_result(sol_result), .sol_out_valid(sol_out_valid),
    .busy(busy), .done(done), .result(result), .bytes_sent(bytes_sent), .err_timeout(err_timeout)
  );

  // RAM: data for a read appears one cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= ram[mem_addr[7:0]];
      rd_cnt = rd_cnt + 1;
      if (mem_addr >= len) addr_bad = addr_bad + 1;
    end
  end

  // Solver: sums the game id of every line committed by LF
  always @(posedge clk) begin
    if (!sol_rst_n) begin
      sum_m   <= 64'd0;
      id_m    <= 0;
      colon_m <= 1'b0;
    end else if (sol_valid && sol_ready) begin
      if (sol_char == 8'h0A) begin
        sum_m   <= sum_m + 64'(id_m);
        id_m    <= 0;
        colon_m <= 1'b0;
      end else if (sol_char == 8'h3A) begin
        colon_m <= 1'b1;
      end else if (!colon_m && sol_char >= 8'h30 && sol_char <= 8'h39) begin
        id_m <= id_m * 10 + (int'(sol_char) - 48);
      end
    end
  end

  assign sol_result    = sum_m;
  assign sol_out_valid = sol_rst_n & ~sol_valid & ~ov_block;

  task automatic load_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      ram[i] = s[i];
      exp_q.push_back(s[i]);
    end
    if (s.len() == 0 || s[s.len()-1] != 8'h0A) exp_q.push_back(8'h0A);
  endtask

  // One full pass: start, drive sol_ready, score every accepted byte until done settles
  task automatic run_pass(input int n, input int mode, output int hs, output int done_cnt,
                          output int done_cyc, output int clr_low, output int rds,
                          output int first_hs, output int last_hs);
    int rd0, stop_at;
    bit seen_hi, prev_stall, fin;
    logic [7:0] prev_char, e;
    hs = 0; done_cnt = 0; done_cyc = -1; clr_low = 0; first_hs = -1; last_hs = -1;
    seen_hi = 0; prev_stall = 0; prev_char = 8'h00; fin = 0; stop_at = 0;
    rd0 = rd_cnt;
    @(posedge clk); #1 len = n[AW-1:0]; start = 1'b1; sol_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
      end
      if (!seen_hi) begin
        if (sol_rst_n === 1'b1) seen_hi = 1; else clr_low++;
      end
      if (prev_stall) begin
        n_cmp++;
        if (sol_valid !== 1'b1 || sol_char !== prev_char) begin
          n_bad++; $display("FAIL stall_hold: got v=%b c=%h want v=1 c=%h", sol_valid, sol_char, prev_char);
        end
      end
      if (sol_valid === 1'b1 && sol_ready === 1'b1) begin
        hs++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL extra_byte: got %h want none", sol_char);
        end else begin
          e = exp_q.pop_front();
          if (sol_char !== e) begin n_bad++; $display("FAIL char: got %h want %h", sol_char, e); end
        end
      end
      prev_stall = (sol_valid === 1'b1) && (sol_ready !== 1'b1);
      prev_char  = sol_char;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; stop_at = cyc + 3; end
      end
      if (done_cyc >= 0 && cyc >= stop_at) fin = 1;
      @(posedge clk); #1 sol_ready = (mode == 0) ? 1'b1 : (((cyc + 1) % 3) == 0);
    end
    if (!fin) begin n_cmp++; n_bad++; $display("FAIL pass_timeout: got no done want done"); end
    rds = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; sol_ready = 1'b0; ov_block = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sol_rst_n !== 1'b0)  begin n_bad++; $display("FAIL rst_sol_rst_n: got %b want 0", sol_rst_n); end
    n_cmp++; if (sol_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_sol_valid: got %b want 0", sol_valid); end
    n_cmp++; if (mem_rd !== 1'b0)     begin n_bad++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (result !== 64'd0)    begin n_bad++; $display("FAIL rst_result: got %h want 0", result); end
    n_cmp++; if (bytes_sent !== '0)   begin n_bad++; $display("FAIL rst_bytes_sent: got %0d want 0", bytes_sent); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_timeout); end
    n_cmp++; if (mem_addr !== '0)     begin n_bad++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_lf();
    int hs, dc, dcyc, cl, rds, f, l;
    load_str("ab\n");
    run_pass(3, 0, hs, dc, dcyc, cl, rds, f, l);
    n_cmp++; if (hs != 3)          begin n_bad++; $display("FAIL basic_hs: got %0d want 3", hs); end
    n_cmp++; if (f != 6)           begin n_bad++; $display("FAIL basic_first_hs: got %0d want 6", f); end
    n_cmp++; if (l - f != 2)       begin n_bad++; $display("FAIL basic_back_to_back: got %0d want 2", l - f); end
    n_cmp++; if (bytes_sent != 3)  begin n_bad++; $display("FAIL basic_bytes: got %0d want 3", bytes_sent); end
    n_cmp++; if (dc != 1)          begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", dc); end
    n_cmp++; if (rds != 3)         begin n_bad++; $display("FAIL basic_reads: got %0d want 3", rds); end
    n_cmp++; if (cl != 4)          begin n_bad++; $display("FAIL basic_clear_len: got %0d want 4", cl); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_append();
    int hs, dc, dcyc, cl, rds, f, l;
    load_str("ab");
    run_pass(2, 0, hs, dc, dcyc, cl, rds, f, l);
    n_cmp++; if (hs != 3)          begin n_bad++; $display("FAIL append_hs: got %0d want 3", hs); end
    n_cmp++; if (bytes_sent != 3)  begin n_bad++; $display("FAIL append_bytes: got %0d want 3", bytes_sent); end
    n_cmp++; if (rds != 2)         begin n_bad++; $display("FAIL append_reads: got %0d want 2", rds); end
    n_cmp++; if (dc != 1)          begin n_bad++; $display("FAIL append_done_cnt: got %0d want 1", dc); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL append_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_day2();
    int hs, dc, dcyc, cl, rds, f, l;
    load_str("Game 7: 3 red\n");
    run_pass(14, 0, hs, dc, dcyc, cl, rds, f, l);
    n_cmp++; if (result !== 64'd7)   begin n_bad++; $display("FAIL day2_result: got %0d want 7", result); end
    n_cmp++; if (hs != 14)           begin n_bad++; $display("FAIL day2_hs: got %0d want 14", hs); end
    n_cmp++; if (bytes_sent != 14)   begin n_bad++; $display("FAIL day2_bytes: got %0d want 14", bytes_sent); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL day2_err: got %b want 0", err_timeout); end
  endtask

  task automatic test_stall();
    int hs, dc, dcyc, cl, rds, f, l, ab0;
    ab0 = addr_bad;
    load_str("Game 12: 4 blue\nGame 30: 2 red");
    run_pass(30, 1, hs, dc, dcyc, cl, rds, f, l);
    n_cmp++; if (hs != 31)            begin n_bad++; $display("FAIL stall_hs: got %0d want 31", hs); end
    n_cmp++; if (bytes_sent != 31)    begin n_bad++; $display("FAIL stall_bytes: got %0d want 31", bytes_sent); end
    n_cmp++; if (rds != 30)           begin n_bad++; $display("FAIL stall_reads: got %0d want 30", rds); end
    n_cmp++; if (addr_bad != ab0)     begin n_bad++; $display("FAIL stall_addr_range: got %0d want %0d", addr_bad, ab0); end
    n_cmp++; if (result !== 64'd42)   begin n_bad++; $display("FAIL stall_result: got %0d want 42", result); end
    n_cmp++; if (dc != 1)             begin n_bad++; $display("FAIL stall_done_cnt: got %0d want 1", dc); end
    n_cmp++; if (exp_q.size() != 0)   begin n_bad++; $display("FAIL stall_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int hs, dc, dcyc, cl, rds, f, l;
    load_str("");
    ov_block = 1'b1;
    run_pass(0, 0, hs, dc, dcyc, cl, rds, f, l);
    ov_block = 1'b0;
    n_cmp++; if (hs != 1)              begin n_bad++; $display("FAIL to_hs: got %0d want 1", hs); end
    n_cmp++; if (bytes_sent != 1)      begin n_bad++; $display("FAIL to_bytes: got %0d want 1", bytes_sent); end
    n_cmp++; if (rds != 0)             begin n_bad++; $display("FAIL to_reads: got %0d want 0", rds); end
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err_timeout); end
    n_cmp++; if (result !== 64'd0)     begin n_bad++; $display("FAIL to_result: got %0d want 0", result); end
    n_cmp++; if (dcyc != 1031)         begin n_bad++; $display("FAIL to_done_cycle: got %0d want 1031", dcyc); end
    n_cmp++; if (dc != 1)              begin n_bad++; $display("FAIL to_done_cnt: got %0d want 1", dc); end
  endtask

  task automatic test_reset_mid();
    int hs, dc, dcyc, cl, rds, f, l;
    bit got;
    got = 0;
    load_str("Game 7: 3 red\n");
    @(posedge clk); #1 len = 16'd14; start = 1'b1; sol_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (sol_valid === 1'b1 && sol_ready === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL mid_reach_stream: got no handshake want handshake"); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (sol_rst_n !== 1'b0)  begin n_bad++; $display("FAIL mid_sol_rst_n: got %b want 0", sol_rst_n); end
    n_cmp++; if (sol_valid !== 1'b0)  begin n_bad++; $display("FAIL mid_sol_valid: got %b want 0", sol_valid); end
    n_cmp++; if (mem_addr !== '0)     begin n_bad++; $display("FAIL mid_mem_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
    @(posedge clk); #1 rst = 1'b0;
    load_str("G");
    run_pass(1, 0, hs, dc, dcyc, cl, rds, f, l);
    n_cmp++; if (cl != 4)             begin n_bad++; $display("FAIL mid_clear_len: got %0d want 4", cl); end
    n_cmp++; if (hs != 2)             begin n_bad++; $display("FAIL mid_hs: got %0d want 2", hs); end
    n_cmp++; if (f != 6)              begin n_bad++; $display("FAIL mid_first_hs: got %0d want 6", f); end
    n_cmp++; if (rds != 1)            begin n_bad++; $display("FAIL mid_reads: got %0d want 1", rds); end
    n_cmp++; if (bytes_sent != 2)     begin n_bad++; $display("FAIL mid_bytes: got %0d want 2", bytes_sent); end
    n_cmp++; if (dc != 1)             begin n_bad++; $display("FAIL mid_done_cnt: got %0d want 1", dc); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_basic_lf();
    test_append();
    test_day2();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
